// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// mem_responder_if : request strobes/operands and completion results
// Revision: 1.0
// ============================================================================
interface mem_responder_if #(
  parameter int WORD = 16
);
  logic            fetch_req;
  logic [WORD-1:0] fetch_addr;
  logic            rd_req;
  logic [WORD-1:0] read_addr;
  logic            wr_req;
  logic [WORD-1:0] write_addr;
  logic [WORD-1:0] data_in;
  logic [WORD-1:0] instr;
  logic [WORD-1:0] imm;
  logic [WORD-1:0] data_out;
  logic            fetch_done;
  logic            read_done;
  logic            write_done;
  logic            busy;
  logic            overrun;

  modport master (
    output fetch_req, fetch_addr, rd_req, read_addr, wr_req, write_addr, data_in,
    input  instr, imm, data_out, fetch_done, read_done, write_done, busy, overrun
  );

  modport slave (
    input  fetch_req, fetch_addr, rd_req, read_addr, wr_req, write_addr, data_in,
    output instr, imm, data_out, fetch_done, read_done, write_done, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : wait-stated storage serving write/read/fetch requests
// Revision: 1.0
// ============================================================================
module mem_responder #(
  parameter int WORD        = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mem_responder_if.slave bus
);
  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC_A = 2'd1, ACC_B = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {SEL_WR = 2'd0, SEL_RD = 2'd1, SEL_FE = 2'd2} sel_t;

  state_t          state_q, state_d;
  sel_t            sel_q, sel_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_pend_q, wr_pend_d;
  logic            rd_pend_q, rd_pend_d;
  logic            fe_pend_q, fe_pend_d;
  logic [WORD-1:0] wr_addr_q, wr_addr_d;
  logic [WORD-1:0] wr_data_q, wr_data_d;
  logic [WORD-1:0] rd_addr_q, rd_addr_d;
  logic [WORD-1:0] fe_addr_q, fe_addr_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] imm_q, imm_d;
  logic [WORD-1:0] data_out_q, data_out_d;
  logic            overrun_q, overrun_d;

  logic            mem_we;
  logic            wr_clr, rd_clr, fe_clr;
  logic [AW-1:0]   wr_idx, rd_idx, fe_idx, imm_idx;
  logic [WORD-1:0] mem [DEPTH];

  // Truncating casts give the mod-DEPTH addressing; imm_idx wraps DEPTH-1 -> 0.
  assign wr_idx  = AW'(wr_addr_q);
  assign rd_idx  = AW'(rd_addr_q);
  assign fe_idx  = AW'(fe_addr_q);
  assign imm_idx = fe_idx + AW'(1);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    wr_clr     = 1'b0;
    rd_clr     = 1'b0;
    fe_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pend_q || rd_pend_q || fe_pend_q) begin
          state_d = ACC_A;
          cnt_d   = WS;
          if (wr_pend_q)      sel_d = SEL_WR;
          else if (rd_pend_q) sel_d = SEL_RD;
          else                sel_d = SEL_FE;
        end
      end
      ACC_A: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          case (sel_q)
            SEL_WR: begin
              mem_we  = 1'b1;
              wr_clr  = 1'b1;
              state_d = DONE;
            end
            SEL_RD: begin
              data_out_d = mem[rd_idx];
              rd_clr     = 1'b1;
              state_d    = DONE;
            end
            default: begin
              instr_d = mem[fe_idx];
              cnt_d   = WS;
              state_d = ACC_B;
            end
          endcase
        end
      end
      ACC_B: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          imm_d   = mem[imm_idx];
          fe_clr  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe is accepted when its slot is free or frees on this very edge.
  always_comb begin
    wr_pend_d = wr_clr ? 1'b0 : wr_pend_q;
    rd_pend_d = rd_clr ? 1'b0 : rd_pend_q;
    fe_pend_d = fe_clr ? 1'b0 : fe_pend_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    fe_addr_d = fe_addr_q;
    overrun_d = overrun_q;
    if (bus.wr_req) begin
      if (!wr_pend_q || wr_clr) begin
        wr_pend_d = 1'b1;
        wr_addr_d = bus.write_addr;
        wr_data_d = bus.data_in;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (bus.rd_req) begin
      if (!rd_pend_q || rd_clr) begin
        rd_pend_d = 1'b1;
        rd_addr_d = bus.read_addr;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (bus.fetch_req) begin
      if (!fe_pend_q || fe_clr) begin
        fe_pend_d = 1'b1;
        fe_addr_d = bus.fetch_addr;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= SEL_WR;
      cnt_q      <= 4'd0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      fe_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      fe_addr_q  <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      data_out_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      fe_pend_q  <= fe_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      fe_addr_q  <= fe_addr_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      data_out_q <= data_out_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage survives reset; mem_we is low whenever the FSM is held in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wr_data_q;
  end

  assign bus.instr      = instr_q;
  assign bus.imm        = imm_q;
  assign bus.data_out   = data_out_q;
  assign bus.write_done = (state_q == DONE) && (sel_q == SEL_WR);
  assign bus.read_done  = (state_q == DONE) && (sel_q == SEL_RD);
  assign bus.fetch_done = (state_q == DONE) && (sel_q == SEL_FE);
  assign bus.busy       = (state_q != IDLE) || wr_pend_q || rd_pend_q || fe_pend_q;
  assign bus.overrun    = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder : directed scoreboard bench (WORD=16, DEPTH=256, WAIT_STATES=1)
// Revision: 1.0
// ============================================================================
module tb_mem_responder;
  localparam int WORD        = 16;
  localparam int DEPTH       = 256;
  localparam int WAIT_STATES = 1;

  localparam logic [2:0] K_WR = 3'b001;
  localparam logic [2:0] K_RD = 3'b010;
  localparam logic [2:0] K_FE = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] data;
    logic [15:0] imm;
    int          lat;
    int          req;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] mon_dv;

  mem_responder_if #(.WORD(WORD)) bus ();

  mem_responder #(
    .WORD       (WORD),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe presented from the falling edge, sampled on the next rising edge.
  task automatic req(input bit w, input bit r, input bit f,
                     input logic [15:0] wa, input logic [15:0] wd,
                     input logic [15:0] ra, input logic [15:0] fa,
                     output int edge_cyc);
    @(negedge clk);
    bus.wr_req     = w;
    bus.write_addr = wa;
    bus.data_in    = wd;
    bus.rd_req     = r;
    bus.read_addr  = ra;
    bus.fetch_req  = f;
    bus.fetch_addr = fa;
    @(posedge clk);
    #1;
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
    bus.fetch_req = 1'b0;
    edge_cyc      = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= 200), 32'd0);
  endtask

  // Completion monitor: every done pulse pops and checks one scoreboard entry.
  always @(negedge clk) begin
    mon_dv = {bus.fetch_done, bus.read_done, bus.write_done};
    if (mon_dv != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(mon_dv), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_kind", 32'(mon_dv), 32'(mon_e.kind));
        if (mon_e.kind == K_RD) check("data_out", 32'(bus.data_out), 32'(mon_e.data));
        if (mon_e.kind == K_FE) begin
          check("instr", 32'(bus.instr), 32'(mon_e.data));
          check("imm", 32'(bus.imm), 32'(mon_e.imm));
        end
        check("latency", 32'(cyc - mon_e.req), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    int rc;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.fetch_req = 1'b0;
    bus.write_addr = '0; bus.data_in = '0; bus.read_addr = '0; bus.fetch_addr = '0;

    repeat (3) @(negedge clk);
    check("rst_instr",    32'(bus.instr), 32'd0);
    check("rst_imm",      32'(bus.imm), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_overrun",  32'(bus.overrun), 32'd0);
    check("rst_dones",    32'({bus.fetch_done, bus.read_done, bus.write_done}), 32'd0);
    rst_n = 1'b1;

    // Write then read back at address 5.
    req(1, 0, 0, 16'd5, 16'h1234, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(0, 1, 0, 16'd0, 16'd0, 16'd5, 16'd0, rc);
    sb.push_back('{K_RD, 16'h1234, 16'h0, 3, rc});
    drain();
    repeat (3) @(negedge clk);
    check("data_out_hold", 32'(bus.data_out), 32'h1234);

    // Fetch of an instruction/immediate pair.
    req(1, 0, 0, 16'd7, 16'h0800, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(1, 0, 0, 16'd8, 16'h002A, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(0, 0, 1, 16'd0, 16'd0, 16'd0, 16'd7, rc);
    sb.push_back('{K_FE, 16'h0800, 16'h002A, 5, rc});
    drain();

    // Fetch at the top address wraps the immediate to address 0.
    req(1, 0, 0, 16'd0, 16'h0011, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(1, 0, 0, 16'd255, 16'hABCD, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(0, 0, 1, 16'd0, 16'd0, 16'd0, 16'd255, rc);
    sb.push_back('{K_FE, 16'hABCD, 16'h0011, 5, rc});
    drain();
    check("instr_hold", 32'(bus.instr), 32'hABCD);

    // Simultaneous write/read/fetch at address 3, serviced write > read > fetch.
    req(1, 0, 0, 16'd4, 16'h4444, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(1, 1, 1, 16'd3, 16'hBEEF, 16'd3, 16'd3, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    sb.push_back('{K_RD, 16'hBEEF, 16'h0, 7, rc});
    sb.push_back('{K_FE, 16'hBEEF, 16'h4444, 13, rc});
    drain();
    check("overrun_simul", 32'(bus.overrun), 32'd0);

    // Read strobe on the completion edge of the previous read is accepted.
    req(0, 1, 0, 16'd0, 16'd0, 16'd5, 16'd0, rc);
    sb.push_back('{K_RD, 16'h1234, 16'h0, 3, rc});
    repeat (2) @(posedge clk);
    req(0, 1, 0, 16'd0, 16'd0, 16'd8, 16'd0, rc);
    sb.push_back('{K_RD, 16'h002A, 16'h0, 4, rc});
    drain();
    check("overrun_setwins", 32'(bus.overrun), 32'd0);

    // Back-to-back read strobes: second dropped, overrun sticky.
    req(0, 1, 0, 16'd0, 16'd0, 16'd5, 16'd0, rc);
    sb.push_back('{K_RD, 16'h1234, 16'h0, 3, rc});
    req(0, 1, 0, 16'd0, 16'd0, 16'd3, 16'd0, rc);
    drain();
    repeat (4) @(negedge clk);
    check("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Reset during a write abandons it; strobes under reset are ignored.
    req(1, 0, 0, 16'd9, 16'h0001, 16'd0, 16'd0, rc);
    sb.push_back('{K_WR, 16'h0, 16'h0, 3, rc});
    drain();
    req(1, 0, 0, 16'd9, 16'h5555, 16'd0, 16'd0, rc);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",    32'(bus.busy), 32'd0);
    check("rst_mid_overrun", 32'(bus.overrun), 32'd0);
    check("rst_mid_wdone",   32'(bus.write_done), 32'd0);
    bus.rd_req = 1'b1; bus.read_addr = 16'd9;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd9;
    repeat (2) @(negedge clk);
    bus.rd_req = 1'b0; bus.fetch_req = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    req(0, 1, 0, 16'd0, 16'd0, 16'd9, 16'd0, rc);
    sb.push_back('{K_RD, 16'h0001, 16'h0, 3, rc});
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WORD, default 16, data/address width in bits.
REQ-002 Parameter DEPTH, default 256, number of words of storage (power of 2).
REQ-003 Parameter WAIT_STATES, default 1, extra cycles per storage access (0..15).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 fetch_req  in  1  one-cycle strobe requesting an instruction fetch.
REQ-007 fetch_addr  in  WORD  instruction address, sampled with fetch_req.
REQ-008 rd_req  in  1  one-cycle strobe requesting a data read.
REQ-009 read_addr  in  WORD  data read address, sampled with rd_req.
REQ-010 wr_req  in  1  one-cycle strobe requesting a data write.
REQ-011 write_addr  in  WORD  data write address, sampled with wr_req.
REQ-012 data_in  in  WORD  write data, sampled with wr_req.
REQ-013 instr  out  WORD  word at fetched address.
REQ-014 imm  out  WORD  word at fetched address + 1.
REQ-015 data_out  out  WORD  word at read address.
REQ-016 fetch_done / read_done / write_done  out  1 each  one-cycle completion pulses.
REQ-017 busy  out  1  high when the FSM is not IDLE or any request is pending.
REQ-018 overrun  out  1  sticky error flag.

Function
REQ-019 Each request type SHALL have one pending flag plus latched address (and data for write), captured on the edge where its strobe is high.
REQ-020 FSM states SHALL be IDLE, ACC_A, ACC_B, DONE.
REQ-021 In IDLE with any flag pending, the next edge SHALL select one request by priority write > read > fetch and enter ACC_A with wait counter loaded to WAIT_STATES.
REQ-022 ACC_A/ACC_B SHALL each last WAIT_STATES+1 cycles; the access is performed on the edge where the counter is zero.
REQ-023 Write completion SHALL store data_in latch at write_addr mod DEPTH; read completion SHALL load data_out from read_addr mod DEPTH.
REQ-024 Fetch SHALL load instr in ACC_A, then enter ACC_B and load imm from (fetch_addr+1) mod DEPTH; wrap from DEPTH-1 to 0.
REQ-025 On completion edge the FSM SHALL enter DONE, assert the matching done pulse for exactly one cycle, and clear that pending flag; DONE returns to IDLE on the next edge.
REQ-026 Latency from request edge to done high SHALL be WAIT_STATES+2 cycles for read/write and 2*WAIT_STATES+3 for fetch, when no other request is in service.
REQ-027 A strobe of a type whose flag is already pending (including the request currently in service) SHALL be dropped, latched operands unchanged, and overrun set; exception: a strobe on the same edge the flag clears SHALL be accepted (set wins).
REQ-028 Simultaneous strobes of different types SHALL all be accepted and serviced sequentially by priority.
REQ-029 instr, imm and data_out SHALL hold their value until their next completion.
REQ-030 A read or fetch serviced after a write SHALL return the written value.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, clear pending flags, counters, all done pulses, busy, overrun, instr, imm, data_out to 0.
REQ-032 Storage contents SHALL NOT be cleared by reset; an access in progress is abandoned with no done pulse and no write.
REQ-033 Strobes while rst_n is low SHALL be ignored.

Verification
REQ-034 WAIT_STATES=1: wr_req addr 5 data 0x1234, after write_done rd_req addr 5 -> read_done at request+3 cycles, data_out=0x1234.
REQ-035 Words 0x0800 at 7, 0x002A at 8; fetch_req addr 7 -> fetch_done at request+5 cycles, instr=0x0800, imm=0x002A.
REQ-036 fetch_req addr 255 (DEPTH=256) with word 0x0011 at 0 -> imm=0x0011.
REQ-037 wr_req, rd_req, fetch_req on same edge, all addr 3, data 0xBEEF -> write_done, then read_done with data_out=0xBEEF, then fetch_done with instr=0xBEEF; overrun stays 0.
REQ-038 rd_req twice on consecutive edges -> one read_done, overrun=1 until reset.
REQ-039 rst_n low mid-write (addr 9, data 0x5555, old 0x0001) -> no write_done, busy=0, addr 9 still 0x0001 after reset release.
